// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage ALU decoder and HI/LO multiply/divide unit:
// ALU op codes, MIPS opcode/funct values, FSM state type and the ALU decode function.
package ex_pkg;

  // ALU operation codes driven to the ALU
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Opcode/funct to ALU op; anything unrecognised falls back to ADD
  function automatic logic [3:0] alu_decode(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] ctrl;
    ctrl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU:  ctrl = ALU_ADD;
          FN_SUB, FN_SUBU:  ctrl = ALU_SUB;
          FN_AND:           ctrl = ALU_AND;
          FN_OR:            ctrl = ALU_OR;
          FN_XOR:           ctrl = ALU_XOR;
          FN_NOR:           ctrl = ALU_NOR;
          FN_SLT:           ctrl = ALU_SLT;
          FN_SLTU:          ctrl = ALU_SLTU;
          FN_SLL, FN_SLLV:  ctrl = ALU_SLL;
          FN_SRL, FN_SRLV:  ctrl = ALU_SRL;
          FN_SRA, FN_SRAV:  ctrl = ALU_SRA;
          default:          ctrl = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE:                       ctrl = ALU_SUB;
      OP_ADDI, OP_ADDIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:                  ctrl = ALU_ADD;
      OP_SLTI:                              ctrl = ALU_SLT;
      OP_SLTIU:                             ctrl = ALU_SLTU;
      OP_ANDI:                              ctrl = ALU_AND;
      OP_ORI:                               ctrl = ALU_OR;
      OP_XORI:                              ctrl = ALU_XOR;
      OP_LUI:                               ctrl = ALU_LUI;
      default:                              ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring-divide datapath. Operates on magnitudes for
// WIDTH cycles after start, then sign-corrects and pulses done with {hi,lo}.
// Divider path present only when MULDIV_DIV_EN is defined.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               active;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // mult: {partial hi, multiplier/lo}; div: {remainder, quotient}
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic               neg_a;
  logic               neg_b;
  logic               start_neg_a;
  logic               start_neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic               div_op;
  logic               b_zero;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   new_rem;
`endif

  assign start_neg_a = is_signed & a[WIDTH-1];
  assign start_neg_b = is_signed & b[WIDTH-1];
  assign mag_a       = start_neg_a ? -a : a;
  assign mag_b       = start_neg_b ? -b : b;

  // One iteration step: shift-add for multiply, trial-subtract for divide
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    ge      = rem_sh >= {1'b0, opnd};
    new_rem = ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
    if (div_op) acc_next = {new_rem, acc[WIDTH-2:0], ge};
`endif
  end

  // Sign correction of the final step's result
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc_next : acc_next;
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (div_op) begin
      // Divide by zero keeps the raw all-ones quotient and the dividend as remainder
      lo = ((neg_a ^ neg_b) & ~b_zero) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      hi = neg_a ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign done = active & (count == LAST);

  // Operand capture on start, one step per cycle while active, abort clears
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      active <= 1'b0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_op <= 1'b0;
      b_zero <= 1'b0;
`endif
    end else if (abort) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      acc    <= {{WIDTH{1'b0}}, mag_a};
      opnd   <= mag_b;
      neg_a  <= start_neg_a;
      neg_b  <= start_neg_b;
`ifdef MULDIV_DIV_EN
      div_op <= is_div;
      b_zero <= (b == '0);
`endif
    end else if (active) begin
      acc   <= acc_next;
      count <= count + CW'(1);
      if (count == LAST) begin
        active <= 1'b0;
        count  <= '0;
      end
    end
  end

endmodule

// File: rtl/ex_alu_muldiv_ctrl.sv
// EX-stage ALU decoder plus HI/LO register file with an iterative MULT/MULTU/DIV/DIVU engine.
// Drives the pipeline stall for HI/LO-class instructions while the engine is busy.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they behave as NOPs.
module ex_alu_muldiv_ctrl
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  output logic [3:0]       o_alu_ctrl,
  output logic             o_hilo_sel,
  output logic [WIDTH-1:0] o_hilo_data,
  output logic             o_busy,
  output logic             o_stall
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_rtype;
  logic             is_mult;
  logic             is_div_op;
  logic             is_signed_op;
  logic             is_mfhi;
  logic             is_mflo;
  logic             is_mthi;
  logic             is_mtlo;
  logic             is_hilo_cls;
  logic             accept;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  assign is_rtype = (i_opcode == OP_RTYPE);
  assign is_mult  = is_rtype & ((i_funct == FN_MULT) | (i_funct == FN_MULTU));
`ifdef MULDIV_DIV_EN
  assign is_div_op    = is_rtype & ((i_funct == FN_DIV) | (i_funct == FN_DIVU));
  assign is_signed_op = (i_funct == FN_MULT) | (i_funct == FN_DIV);
`else
  assign is_div_op    = 1'b0;
  assign is_signed_op = (i_funct == FN_MULT);
`endif
  assign is_mfhi     = is_rtype & (i_funct == FN_MFHI);
  assign is_mflo     = is_rtype & (i_funct == FN_MFLO);
  assign is_mthi     = is_rtype & (i_funct == FN_MTHI);
  assign is_mtlo     = is_rtype & (i_funct == FN_MTLO);
  assign is_hilo_cls = is_mult | is_div_op | is_mfhi | is_mflo | is_mthi | is_mtlo;

  assign accept = (state == ST_IDLE) & i_valid & ~i_flush & (is_mult | is_div_op);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .abort     (i_flush),
`ifdef MULDIV_DIV_EN
    .is_div    (is_div_op),
`endif
    .is_signed (is_signed_op),
    .a         (i_rs_data),
    .b         (i_rt_data),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state: start on accept, leave on final step or flush
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)             state_next = ST_BUSY;
      ST_BUSY: if (i_flush | md_done)  state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and stall for HI/LO-dependent instructions
  always_comb begin
    o_busy  = (state == ST_BUSY);
    o_stall = i_valid & o_busy & is_hilo_cls;
  end

  // HI/LO registers: engine result on completion, MTHI/MTLO when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_BUSY) begin
      if (md_done & ~i_flush) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end
    end else if (i_valid & ~i_flush) begin
      if (is_mthi) hi_q <= i_rs_data;
      if (is_mtlo) lo_q <= i_rs_data;
    end
  end

  // ALU op decode and MFHI/MFLO read path
  always_comb begin
    o_alu_ctrl  = alu_decode(i_opcode, i_funct);
    o_hilo_sel  = i_valid & (is_mfhi | is_mflo);
    o_hilo_data = '0;
    if (is_mfhi)      o_hilo_data = hi_q;
    else if (is_mflo) o_hilo_data = lo_q;
  end

endmodule

// File: tb/tb_ex_alu_muldiv_ctrl.sv
// Directed self-checking bench for ex_alu_muldiv_ctrl (WIDTH=32).
module tb_ex_alu_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_flush;
  logic [5:0]  i_opcode;
  logic [5:0]  i_funct;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [3:0]  o_alu_ctrl;
  logic        o_hilo_sel;
  logic [31:0] o_hilo_data;
  logic        o_busy;
  logic        o_stall;

  int tests = 0;
  int fails = 0;

  ex_alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_flush     (i_flush),
    .i_opcode    (i_opcode),
    .i_funct     (i_funct),
    .i_rs_data   (i_rs_data),
    .i_rt_data   (i_rt_data),
    .o_alu_ctrl  (o_alu_ctrl),
    .o_hilo_sel  (o_hilo_sel),
    .o_hilo_data (o_hilo_data),
    .o_busy      (o_busy),
    .o_stall     (o_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    i_valid   = v;
    i_opcode  = op;
    i_funct   = fn;
    i_rs_data = a;
    i_rt_data = b;
    #1;
  endtask

  task automatic dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic [3:0] exp);
    drive(1'b1, op, fn, 32'h0, 32'h0);
    check(tag, {28'h0, o_alu_ctrl}, {28'h0, exp});
  endtask

  // Read HI and LO through MFHI/MFLO (combinational, no clock edge)
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    drive(1'b1, 6'b000000, 6'b010000, 32'h0, 32'h0);
    hi = o_hilo_data;
    drive(1'b1, 6'b000000, 6'b010010, 32'h0, 32'h0);
    lo = o_hilo_data;
    drive(1'b0, 6'b000000, 6'b000000, 32'h0, 32'h0);
  endtask

  // Issue a mul/div for one cycle, then count cycles o_busy stays high
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    drive(1'b1, 6'b000000, fn, a, b);
    tick();
    drive(1'b0, 6'b000000, 6'b000000, 32'h0, 32'h0);
    cycles = 0;
    while (o_busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] hi, lo;
    int n;

    reset   = 1'b1;
    i_flush = 1'b0;
    drive(1'b0, 6'b0, 6'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("reset_busy", {31'h0, o_busy}, 32'h0);
    drive(1'b1, 6'b000000, 6'b010010, 32'h0, 32'h0);
    check("reset_stall", {31'h0, o_stall}, 32'h0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    // Decode sweep
    dec("dec_beq",   6'b000100, 6'h00, 4'h1);
    dec("dec_bne",   6'b000101, 6'h00, 4'h1);
    dec("dec_addi",  6'b001000, 6'h00, 4'h0);
    dec("dec_addiu", 6'b001001, 6'h00, 4'h0);
    dec("dec_lw",    6'b100011, 6'h00, 4'h0);
    dec("dec_lbu",   6'b100100, 6'h00, 4'h0);
    dec("dec_sw",    6'b101011, 6'h00, 4'h0);
    dec("dec_slti",  6'b001010, 6'h00, 4'h6);
    dec("dec_sltiu", 6'b001011, 6'h00, 4'h7);
    dec("dec_andi",  6'b001100, 6'h00, 4'h2);
    dec("dec_ori",   6'b001101, 6'h00, 4'h3);
    dec("dec_xori",  6'b001110, 6'h00, 4'h4);
    dec("dec_lui",   6'b001111, 6'h00, 4'hB);
    dec("dec_add",   6'b000000, 6'b100000, 4'h0);
    dec("dec_addu",  6'b000000, 6'b100001, 4'h0);
    dec("dec_sub",   6'b000000, 6'b100010, 4'h1);
    dec("dec_subu",  6'b000000, 6'b100011, 4'h1);
    dec("dec_and",   6'b000000, 6'b100100, 4'h2);
    dec("dec_or",    6'b000000, 6'b100101, 4'h3);
    dec("dec_xor",   6'b000000, 6'b100110, 4'h4);
    dec("dec_nor",   6'b000000, 6'b100111, 4'h5);
    dec("dec_slt",   6'b000000, 6'b101010, 4'h6);
    dec("dec_sltu",  6'b000000, 6'b101011, 4'h7);
    dec("dec_sll",   6'b000000, 6'b000000, 4'h8);
    dec("dec_sllv",  6'b000000, 6'b000100, 4'h8);
    dec("dec_srl",   6'b000000, 6'b000010, 4'h9);
    dec("dec_srlv",  6'b000000, 6'b000110, 4'h9);
    dec("dec_sra",   6'b000000, 6'b000011, 4'hA);
    dec("dec_srav",  6'b000000, 6'b000111, 4'hA);
    dec("dec_bad_fn", 6'b000000, 6'b111111, 4'h0);
    drive(1'b0, 6'b0, 6'b0, 32'h0, 32'h0);

    // MULT -2 * 3
    run_op(6'b011000, 32'hFFFF_FFFE, 32'h0000_0003, n);
    check("mult_busy_cycles", n, 32);
    read_hilo(hi, lo);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFE * 3
    run_op(6'b011001, 32'hFFFF_FFFE, 32'h0000_0003, n);
    check("multu_busy_cycles", n, 32);
    read_hilo(hi, lo);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

`ifdef MULDIV_DIV_EN
    // DIV -7 / 2
    run_op(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, n);
    check("div_busy_cycles", n, 32);
    read_hilo(hi, lo);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // DIVU 7 / 0
    run_op(6'b011011, 32'h0000_0007, 32'h0000_0000, n);
    check("divu0_busy_cycles", n, 32);
    read_hilo(hi, lo);
    check("divu0_hi", hi, 32'h0000_0007);
    check("divu0_lo", lo, 32'hFFFF_FFFF);

    // DIV MIN / -1
    run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divmin_busy_cycles", n, 32);
    read_hilo(hi, lo);
    check("divmin_hi", hi, 32'h0000_0000);
    check("divmin_lo", lo, 32'h8000_0000);
`endif

    // MFLO waiting on MULT 5 * -3: one empty cycle after MULT, then MFLO stalls
    drive(1'b1, 6'b000000, 6'b011000, 32'h0000_0005, 32'hFFFF_FFFD);
    check("issue_no_stall", {31'h0, o_stall}, 32'h0);
    tick();
    drive(1'b0, 6'b000000, 6'b000000, 32'h0, 32'h0);
    tick();
    drive(1'b1, 6'b000000, 6'b010010, 32'h0, 32'h0);
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    check("mflo_stall_cycles", n, 31);
    check("mflo_busy_after", {31'h0, o_busy}, 32'h0);
    check("mflo_sel", {31'h0, o_hilo_sel}, 32'h1);
    check("mflo_data", o_hilo_data, 32'hFFFF_FFF1);
    drive(1'b0, 6'b0, 6'b0, 32'h0, 32'h0);

    // Flush at busy cycle 10 with HI/LO preloaded
    drive(1'b1, 6'b000000, 6'b010001, 32'h0000_1234, 32'h0);
    tick();
    drive(1'b1, 6'b000000, 6'b010011, 32'h0000_5678, 32'h0);
    tick();
    drive(1'b1, 6'b000000, 6'b011000, 32'h0000_0011, 32'h0000_0022);
    tick();
    drive(1'b0, 6'b000000, 6'b000000, 32'h0, 32'h0);
    for (int i = 1; i < 10; i++) tick();
    check("flush_busy_before", {31'h0, o_busy}, 32'h1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #1;
    check("flush_busy_after", {31'h0, o_busy}, 32'h0);
    for (int i = 0; i < 40; i++) tick();
    read_hilo(hi, lo);
    check("flush_hi_kept", hi, 32'h0000_1234);
    check("flush_lo_kept", lo, 32'h0000_5678);

    // Reset at busy cycle 5
    drive(1'b1, 6'b000000, 6'b011001, 32'h0000_0003, 32'h0000_0004);
    tick();
    drive(1'b0, 6'b000000, 6'b000000, 32'h0, 32'h0);
    for (int i = 1; i < 5; i++) tick();
    check("rst_busy_before", {31'h0, o_busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy_after", {31'h0, o_busy}, 32'h0);
    read_hilo(hi, lo);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

`ifndef MULDIV_DIV_EN
    // Without the divider, DIV/DIVU are NOPs: no busy, no stall, HI/LO untouched
    drive(1'b1, 6'b000000, 6'b011010, 32'h0000_0007, 32'h0000_0002);
    check("nodiv_stall", {31'h0, o_stall}, 32'h0);
    tick();
    check("nodiv_busy", {31'h0, o_busy}, 32'h0);
    drive(1'b1, 6'b000000, 6'b011011, 32'h0000_0009, 32'h0000_0003);
    tick();
    check("nodivu_busy", {31'h0, o_busy}, 32'h0);
    read_hilo(hi, lo);
    check("nodiv_hi", hi, 32'h0);
    check("nodiv_lo", lo, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
